// File: rtl/alu_result_buffer_if.sv
// Handshake bus between the ALU, alu_result_buffer and its consumer.
// slave = buffer side, master = producer/consumer side.
interface alu_result_buffer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       f_in;
    logic [WIDTH-1:0] y_in;
    logic             of_in;
    logic             zero_in;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       f_out;
    logic [WIDTH-1:0] y_out;
    logic             of_out;
    logic             zero_out;

    modport slave (
        input  in_valid, f_in, y_in, of_in, zero_in, out_ready,
        output in_ready, out_valid, f_out, y_out, of_out, zero_out
    );

    modport master (
        output in_valid, f_in, y_in, of_in, zero_in, out_ready,
        input  in_ready, out_valid, f_out, y_out, of_out, zero_out
    );
endinterface

// File: rtl/alu_result_buffer.sv
// FIFO buffer for ALU results with saturating overflow/zero statistics.
// Define ALU_RESULT_BYPASS_EN to pass results straight through an empty buffer.
module alu_result_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    alu_result_buffer_if.slave       bus,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     clr_stats,
    output logic [CNT_W-1:0]         of_cnt,
    output logic [CNT_W-1:0]         zero_cnt
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = WIDTH + 5;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rdy_q, rdy_d;
    logic [CNT_W-1:0] of_cnt_q, of_cnt_d;
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;

    logic          push, pop, store, byp, not_empty, of_inc, zero_inc;
    logic [EW-1:0] entry_in, head, shown;

    always_comb begin
        entry_in  = {bus.f_in, bus.y_in, bus.of_in, bus.zero_in};
        head      = mem_q[rd_ptr_q];
        not_empty = (count_q != '0);
        push      = bus.in_valid & rdy_q;
        pop       = not_empty & bus.out_ready;
`ifdef ALU_RESULT_BYPASS_EN
        byp       = ~not_empty & bus.in_valid & bus.out_ready & rdy_q;
`else
        byp       = 1'b0;
`endif
        // A bypassed result is consumed this cycle, so it never occupies a slot.
        store     = push & ~byp;
        shown     = byp ? entry_in : head;

        bus.in_ready  = rdy_q;
        bus.out_valid = not_empty | byp;
        bus.f_out     = shown[EW-1 -: 3];
        bus.y_out     = shown[WIDTH+1:2];
        bus.of_out    = shown[1];
        bus.zero_out  = shown[0];

        mem_d = mem_q;
        if (store) begin
            mem_d[wr_ptr_q] = entry_in;
        end
        wr_ptr_d = store ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (store && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !store) begin
            count_d = count_q - CW'(1);
        end
        // Registered so in_ready stays low through reset and never sees out_ready.
        rdy_d = (count_d != CW'(DEPTH));

        of_inc   = push & bus.of_in;
        zero_inc = push & bus.zero_in;
        if (clr_stats) begin
            of_cnt_d   = CNT_W'(of_inc);
            zero_cnt_d = CNT_W'(zero_inc);
        end else begin
            of_cnt_d   = (of_inc && of_cnt_q != '1) ? of_cnt_q + CNT_W'(1) : of_cnt_q;
            zero_cnt_d = (zero_inc && zero_cnt_q != '1) ? zero_cnt_q + CNT_W'(1) : zero_cnt_q;
        end

        count    = count_q;
        of_cnt   = of_cnt_q;
        zero_cnt = zero_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rdy_q      <= 1'b0;
            of_cnt_q   <= '0;
            zero_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rdy_q      <= rdy_d;
            of_cnt_q   <= of_cnt_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer; second instance uses CNT_W=2 for saturation.
module tb_alu_result_buffer;
    logic       clk = 1'b0;
    logic       reset;
    logic       clr_stats;
    logic [2:0] count, count2;
    logic [15:0] of_cnt, zero_cnt;
    logic [1:0]  of_cnt2, zero_cnt2;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    alu_result_buffer_if #(.WIDTH(32)) ifc ();
    alu_result_buffer_if #(.WIDTH(32)) ifc2 ();

    assign ifc2.in_valid  = ifc.in_valid;
    assign ifc2.f_in      = ifc.f_in;
    assign ifc2.y_in      = ifc.y_in;
    assign ifc2.of_in     = ifc.of_in;
    assign ifc2.zero_in   = ifc.zero_in;
    assign ifc2.out_ready = ifc.out_ready;

    alu_result_buffer #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(ifc.slave), .count(count),
        .clr_stats(clr_stats), .of_cnt(of_cnt), .zero_cnt(zero_cnt)
    );

    alu_result_buffer #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .bus(ifc2.slave), .count(count2),
        .clr_stats(clr_stats), .of_cnt(of_cnt2), .zero_cnt(zero_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] y,
                         input logic o, input logic z);
        ifc.in_valid = v;
        ifc.f_in     = f;
        ifc.y_in     = y;
        ifc.of_in    = o;
        ifc.zero_in  = z;
    endtask

    task automatic drain();
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 8 && count != 0; i++) tick();
        check("drain_empty", 64'(count), 64'd0);
        ifc.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        clr_stats = 1'b0;
        ifc.out_ready = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);

        // 1. reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("rst_y_out", 64'(ifc.y_out), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_of_cnt", 64'(of_cnt), 64'd0);
        check("rst_in_ready_low", 64'(ifc.in_ready), 64'd0);
        reset = 1'b1;
        tick();
        check("rel_in_ready", 64'(ifc.in_ready), 64'd1);

        // 2. single push
        drive(1'b1, 3'd2, 32'h0000_0005, 1'b0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        check("single_valid", 64'(ifc.out_valid), 64'd1);
        check("single_y", 64'(ifc.y_out), 64'd5);
        check("single_f", 64'(ifc.f_out), 64'd2);
        check("single_count", 64'(count), 64'd1);
        ifc.out_ready = 1'b1;
        tick();
        check("single_pop_count", 64'(count), 64'd0);
        check("single_pop_valid", 64'(ifc.out_valid), 64'd0);
        ifc.out_ready = 1'b0;

        // 3. fill and back-pressure
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 3'd1, 32'(i), 1'b0, 1'b0);
            tick();
        end
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(ifc.in_ready), 64'd0);
        drive(1'b1, 3'd1, 32'd5, 1'b0, 1'b0);
        tick();
        check("held_count", 64'(count), 64'd4);
        check("held_y_stable", 64'(ifc.y_out), 64'd1);
        ifc.out_ready = 1'b1;
        tick();
        check("pop_at_full_no_push", 64'(count), 64'd3);
        check("ready_after_pop", 64'(ifc.in_ready), 64'd1);
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            check("drain_order", 64'(ifc.y_out), 64'(k));
            tick();
        end
        check("drain_count", 64'(count), 64'd0);
        ifc.out_ready = 1'b0;

        // 4. simultaneous push/pop at count=2 across wrap
        drive(1'b1, 3'd3, 32'd100, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd3, 32'd101, 1'b0, 1'b0); tick();
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'd3, 32'(102 + i), 1'b0, 1'b0);
            check("pp_head", 64'(ifc.y_out), 64'(100 + i));
            tick();
            check("pp_count", 64'(count), 64'd2);
        end
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        check("pp_tail0", 64'(ifc.y_out), 64'd110);
        tick();
        check("pp_tail1", 64'(ifc.y_out), 64'd111);
        tick();
        check("pp_empty", 64'(count), 64'd0);
        ifc.out_ready = 1'b0;

        // 5. statistics
        drive(1'b1, 3'd0, 32'd7, 1'b1, 1'b0); tick();
        drive(1'b1, 3'd0, 32'd0, 1'b1, 1'b1); tick();
        drive(1'b1, 3'd0, 32'd9, 1'b1, 1'b0); tick();
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        check("stat_of_cnt", 64'(of_cnt), 64'd3);
        check("stat_zero_cnt", 64'(zero_cnt), 64'd1);
        check("stat_sat_of3", 64'(of_cnt2), 64'd3);
        clr_stats = 1'b1;
        drive(1'b1, 3'd0, 32'd11, 1'b1, 1'b0);
        tick();
        clr_stats = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        check("clr_of_cnt", 64'(of_cnt), 64'd1);
        check("clr_zero_cnt", 64'(zero_cnt), 64'd0);
        check("clr_sat_of", 64'(of_cnt2), 64'd1);
        drain();
        check("pop_keeps_stats", 64'(of_cnt), 64'd1);
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd4, 32'(i), 1'b1, 1'b0);
            tick();
            if (i == 1) check("sat_reach", 64'(of_cnt2), 64'd3);
        end
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        check("sat_hold", 64'(of_cnt2), 64'd3);
        check("wide_of_cnt", 64'(of_cnt), 64'd6);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_only", 64'(of_cnt), 64'd0);
        drain();

        // 6. empty buffer with consumer ready
        ifc.out_ready = 1'b1;
        drive(1'b1, 3'd5, 32'hFFFF_FFFF, 1'b0, 1'b0);
        #1;
`ifdef ALU_RESULT_BYPASS_EN
        check("byp_same_valid", 64'(ifc.out_valid), 64'd1);
        check("byp_same_y", 64'(ifc.y_out), 64'hFFFF_FFFF);
        tick();
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        check("byp_count", 64'(count), 64'd0);
        check("byp_after_valid", 64'(ifc.out_valid), 64'd0);
`else
        check("nobyp_same_valid", 64'(ifc.out_valid), 64'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        check("nobyp_next_valid", 64'(ifc.out_valid), 64'd1);
        check("nobyp_next_y", 64'(ifc.y_out), 64'hFFFF_FFFF);
        check("nobyp_count", 64'(count), 64'd1);
        tick();
        check("nobyp_popped", 64'(count), 64'd0);
`endif
        ifc.out_ready = 1'b0;

        // reset mid-traffic
        drive(1'b1, 3'd6, 32'hABCD_0001, 1'b1, 1'b0); tick();
        drive(1'b1, 3'd6, 32'hABCD_0002, 1'b0, 1'b0); tick();
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        check("pre_rst_count", 64'(count), 64'd2);
        reset = 1'b0;
        #1;
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_valid", 64'(ifc.out_valid), 64'd0);
        check("mid_rst_y", 64'(ifc.y_out), 64'd0);
        check("mid_rst_of_cnt", 64'(of_cnt), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_ready", 64'(ifc.in_ready), 64'd1);
        check("post_rst_valid", 64'(ifc.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
Downstream stage of the 32-bit ALU (f[2:0], a, b -> y, OF, zero).
- Captures each ALU result with its function code and flags into a DEPTH-entry FIFO.
- Returns results to the consumer over a valid/ready handshake.
- Keeps saturating statistics counters of overflow results and zero results.
- Decouples the combinational ALU from a consumer that may stall.

Parameters:
WIDTH, 32, data width of y; matches the ALU result width.
DEPTH, 4, number of FIFO entries; power of two, at least 2.
CNT_W, 16, width of each statistics counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  ALU result on f_in/y_in/of_in/zero_in is valid
in_ready  output  1  buffer can accept an entry this cycle
f_in  input  3  ALU function code that produced the result
y_in  input  WIDTH  ALU result
of_in  input  1  ALU overflow flag
zero_in  input  1  ALU zero flag
out_valid  output  1  head entry available
out_ready  input  1  consumer takes the head entry this cycle
f_out  output  3  head entry function code
y_out  output  WIDTH  head entry result
of_out  output  1  head entry overflow flag
zero_out  output  1  head entry zero flag
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
clr_stats  input  1  synchronous clear of of_cnt and zero_cnt
of_cnt  output  CNT_W  number of accepted entries with of_in=1
zero_cnt  output  CNT_W  number of accepted entries with zero_in=1

Behaviour:
Reset (async assert, deassert synchronous to clk):
- Pointers, count, of_cnt and zero_cnt go to 0.
- out_valid=0. f_out=0, y_out=0, of_out=0, zero_out=0 (all storage cleared).
- in_ready=0 while reset is asserted; in_ready=1 in the first cycle after deassert.
- Reset mid-traffic discards all entries; no partial entry survives.

Handshake:
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH), decoded from registered state only. It never depends on out_ready, so there is no combinational in->out path.
- out_valid = (count != 0). Outputs show the head entry and are stable while out_valid=1 and out_ready=0.
- Latency: an entry pushed at edge N is visible at the outputs after edge N, with out_valid=1 in cycle N+1.

Occupancy:
- push only: count+1. pop only: count-1. Both: count unchanged, head advances, tail written.
- Full (count=DEPTH): in_ready=0. A pop in the same cycle does not admit a push; in_ready returns to 1 the following cycle.
- Empty (count=0): out_valid=0 and out_ready is ignored.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
- Entries leave in strict FIFO order.

Statistics:
- On push with of_in=1, of_cnt increments. On push with zero_in=1, zero_cnt increments.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- clr_stats=1: each counter loads 0 plus that cycle's increment (1 if the event occurs), so no event is lost.
- Counters are unaffected by pop.

Optional Feature:
Macro ALU_RESULT_BYPASS_EN.
- Defined: when count=0, in_valid=1 and out_ready=1, the input passes combinationally to the outputs (out_valid=1 in the same cycle) and is not stored. Statistics still count it. count stays 0.
- Not defined: the path is always registered with one cycle minimum latency, as described above.

Test Plan:
1. Reset: hold reset=0 for 3 cycles, then release -> out_valid=0, y_out=0, count=0, of_cnt=0; in_ready=1 one cycle after release.
2. Single push, no bypass: push f=2, y=32'h0000_0005, of=0, zero=0 with out_ready=0 -> next cycle out_valid=1, y_out=5, count=1; assert out_ready -> count=0.
3. Fill and back-pressure: push 5 entries y=1..5 with out_ready=0, DEPTH=4 -> in_ready=0 after the 4th push and the 5th is held off; drain -> y_out order 1,2,3,4; in_ready=1 after the first pop.
4. Simultaneous push/pop at count=2 over 10 cycles -> count stays 2; order preserved across pointer wrap.
5. Stats: push 3 entries with of=1 (one of them with zero=1), then assert clr_stats together with an of=1 push -> of_cnt=3, zero_cnt=1 before the clear; of_cnt=1, zero_cnt=0 after. With CNT_W=2, 5 overflow pushes -> of_cnt=3 (saturated).
6. With ALU_RESULT_BYPASS_EN, empty buffer, out_ready=1, push y=32'hFFFF_FFFF -> out_valid=1 and y_out=FFFF_FFFF in the same cycle, count stays 0. Without the macro -> out_valid=1 on the next cycle.
